// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI target engine.
//   spi_lane_mode_e : single-lane or quad-lane transfer mode
//   spi_tgt_state_e : target FSM states
//   lane_drive()    : maps the head of a TX byte onto the DQ lanes
//   last_edge_cnt() : bit-counter value at the final rising edge of a byte
package spi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned QUAD_W = 4;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {
        SPI_SINGLE = 1'b0,
        SPI_QUAD   = 1'b1
    } spi_lane_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_tgt_state_e;

    // Single mode drives the MSB on lane 1 only; quad drives the high nibble.
    function automatic logic [QUAD_W-1:0] lane_drive(input logic [BYTE_W-1:0] b,
                                                     input spi_lane_mode_e    m);
        logic [QUAD_W-1:0] lanes;
        if (m == SPI_QUAD) begin
            lanes = b[BYTE_W-1 -: QUAD_W];
        end else begin
            lanes = {2'b00, b[BYTE_W-1], 1'b0};
        end
        return lanes;
    endfunction

    // 8 edges per byte in single mode, 2 in quad mode.
    function automatic logic [CNT_W-1:0] last_edge_cnt(input spi_lane_mode_e m);
        return (m == SPI_QUAD) ? CNT_W'(1) : CNT_W'(7);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with registered
// single-cycle rise/fall pulses.
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous input
//   rise, fall : one-cycle pulses, one cycle after the synchronised edge is seen
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] pipe;
    logic              hist;

    // Synchroniser chain, history flop and registered edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= {STAGES{RESET_VAL}};
            hist <= RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            pipe <= {pipe[STAGES-2:0], din};
            hist <= pipe[STAGES-1];
            rise <= pipe[STAGES-1] & ~hist;
            fall <= ~pipe[STAGES-1] & hist;
        end
    end

endmodule

// File: rtl/spi_target.sv
// SPI target (slave) engine, mode 0, MSB first, single or quad lanes.
// Oversamples the master's cs_n/sclk/dq on clk; deserialises into a pulsed RX
// stream and serialises a valid/ready TX stream onto spi_dq_i.
//   spi_cs_n, spi_sclk, spi_dq_o, spi_dq_oen : master-side pins (asynchronous)
//   spi_dq_i                                 : target-driven data lanes
//   quad_en                                  : lane mode, captured at CS assertion
//   rx_data/rx_valid                         : received byte, one-cycle pulse
//   tx_data/tx_valid/tx_ready                : TX byte stream, ready is a pulse
//   busy, tx_underrun, quad_conflict         : status
// DWIDTH must be 4: single mode receives on lane 0 and transmits on lane 1.
import spi_pkg::*;

module spi_target #(
    parameter int unsigned DWIDTH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic [DWIDTH-1:0] spi_dq_o,
    input  logic [DWIDTH-1:0] spi_dq_oen,
    output logic [DWIDTH-1:0] spi_dq_i,
    input  logic              quad_en,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              tx_underrun,
    output logic              quad_conflict
);

    logic cs_rise, cs_fall;
    logic sclk_rise, sclk_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Data and output-enable synchronisers; one stage deeper than the sclk
    // path is unnecessary because data is stable around the sampling edge.
    logic [SYNC_STAGES-1:0][DWIDTH-1:0] dq_pipe;
    logic [SYNC_STAGES-1:0][DWIDTH-1:0] oen_pipe;
    logic [DWIDTH-1:0]                  dq_s;
    logic [DWIDTH-1:0]                  oen_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_pipe  <= '0;
            oen_pipe <= '0;
        end else begin
            dq_pipe  <= {dq_pipe[SYNC_STAGES-2:0], spi_dq_o};
            oen_pipe <= {oen_pipe[SYNC_STAGES-2:0], spi_dq_oen};
        end
    end

    assign dq_s  = dq_pipe[SYNC_STAGES-1];
    assign oen_s = oen_pipe[SYNC_STAGES-1];

    spi_tgt_state_e state_q, state_d;

    spi_lane_mode_e    mode_q, mode_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              byte_done_q, byte_done_d;
    logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic [DWIDTH-1:0] spi_dq_i_d;
    logic [7:0]        rx_data_d;
    logic              rx_valid_d, tx_ready_d, busy_d, tx_underrun_d, quad_conflict_d;

    logic [BYTE_W-1:0] rx_in;
    logic [BYTE_W-1:0] tx_shifted;
    logic [BYTE_W-1:0] tx_load;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: CS deassertion wins over everything else.
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else if ((state_q == ST_IDLE) && cs_fall) begin
            state_d = ST_ACTIVE;
        end
    end

    assign rx_in      = (mode_q == SPI_QUAD) ? {rx_shift_q[3:0], dq_s[3:0]}
                                             : {rx_shift_q[6:0], dq_s[0]};
    assign tx_shifted = (mode_q == SPI_QUAD) ? {tx_shift_q[3:0], 4'h0}
                                             : {tx_shift_q[6:0], 1'b0};
    assign tx_load    = tx_valid ? tx_data : FILL_BYTE;

    // Output/datapath next values.
    always_comb begin
        mode_d          = mode_q;
        bit_cnt_d       = bit_cnt_q;
        byte_done_d     = byte_done_q;
        rx_shift_d      = rx_shift_q;
        tx_shift_d      = tx_shift_q;
        spi_dq_i_d      = spi_dq_i;
        rx_data_d       = rx_data;
        rx_valid_d      = 1'b0;
        tx_ready_d      = 1'b0;
        tx_underrun_d   = 1'b0;
        quad_conflict_d = 1'b0;
        busy_d          = (state_d == ST_ACTIVE);

        if (cs_rise) begin
            // Abort: partial RX byte and any loaded TX byte are discarded.
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            rx_shift_d  = '0;
            spi_dq_i_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        mode_d        = quad_en ? SPI_QUAD : SPI_SINGLE;
                        bit_cnt_d     = '0;
                        byte_done_d   = 1'b0;
                        rx_shift_d    = '0;
                        tx_shift_d    = tx_load;
                        tx_ready_d    = tx_valid;
                        tx_underrun_d = ~tx_valid;
                        spi_dq_i_d    = DWIDTH'(lane_drive(tx_load, mode_d));
                    end
                end
                ST_ACTIVE: begin
                    if (sclk_rise) begin
                        rx_shift_d      = rx_in;
                        quad_conflict_d = (mode_q == SPI_QUAD) && (|oen_s);
                        if (bit_cnt_q == last_edge_cnt(mode_q)) begin
                            bit_cnt_d   = '0;
                            byte_done_d = 1'b1;
                            rx_data_d   = rx_in;
                            rx_valid_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (sclk_fall) begin
                        if (byte_done_q) begin
                            // Falling edge after a completed byte starts the next one.
                            byte_done_d   = 1'b0;
                            tx_shift_d    = tx_load;
                            tx_ready_d    = tx_valid;
                            tx_underrun_d = ~tx_valid;
                            spi_dq_i_d    = DWIDTH'(lane_drive(tx_load, mode_q));
                        end else begin
                            tx_shift_d = tx_shifted;
                            spi_dq_i_d = DWIDTH'(lane_drive(tx_shifted, mode_q));
                        end
                    end
                end
                default: begin
                    spi_dq_i_d = '0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= SPI_SINGLE;
            bit_cnt_q     <= '0;
            byte_done_q   <= 1'b0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            spi_dq_i      <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            tx_ready      <= 1'b0;
            busy          <= 1'b0;
            tx_underrun   <= 1'b0;
            quad_conflict <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_done_q   <= byte_done_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            spi_dq_i      <= spi_dq_i_d;
            rx_data       <= rx_data_d;
            rx_valid      <= rx_valid_d;
            tx_ready      <= tx_ready_d;
            busy          <= busy_d;
            tx_underrun   <= tx_underrun_d;
            quad_conflict <= quad_conflict_d;
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a behavioural SPI master plus RX/TX scoreboards.
module tb_spi_target;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic [3:0] spi_dq_o;
    logic [3:0] spi_dq_oen;
    logic [3:0] spi_dq_i;
    logic       quad_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_underrun;
    logic       quad_conflict;

    always #5 clk = ~clk;

    spi_target #(.DWIDTH(4), .SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_cs_n     (spi_cs_n),
        .spi_sclk     (spi_sclk),
        .spi_dq_o     (spi_dq_o),
        .spi_dq_oen   (spi_dq_oen),
        .spi_dq_i     (spi_dq_i),
        .quad_en      (quad_en),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .tx_underrun  (tx_underrun),
        .quad_conflict(quad_conflict)
    );

    int checks   = 0;
    int failures = 0;
    int n_rx     = 0;
    int n_txr    = 0;
    int n_und    = 0;
    int n_qc     = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: RX scoreboard, pulse counters and the TX byte source.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                n_rx++;
                if (rx_q.size() == 0) begin
                    check("rx_unexpected", {24'h0, rx_data}, 32'h100);
                end else begin
                    mon_exp = rx_q.pop_front();
                    check("rx_data", {24'h0, rx_data}, {24'h0, mon_exp});
                end
            end
            if (tx_ready) begin
                n_txr++;
                if (tx_q.size() > 0) void'(tx_q.pop_front());
            end
            if (tx_underrun)   n_und++;
            if (quad_conflict) n_qc++;
        end
        tx_valid = (tx_q.size() > 0);
        tx_data  = tx_valid ? tx_q[0] : 8'h00;
    end

    task automatic half_wait();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_start(input bit quad);
        quad_en = quad;
        @(negedge clk);
        spi_cs_n = 1'b0;
        half_wait();
    endtask

    // Deassert CS while sclk is still high so no trailing falling edge is seen.
    task automatic cs_end();
        half_wait();
        spi_cs_n = 1'b1;
        half_wait();
        spi_sclk = 1'b0;
        half_wait();
    endtask

    task automatic sclk_edge(input logic [3:0] d, output logic [3:0] s);
        spi_sclk = 1'b0;
        spi_dq_o = d;
        half_wait();
        s = spi_dq_i;
        spi_sclk = 1'b1;
        half_wait();
    endtask

    task automatic xfer(input logic [7:0] b, input bit quad, output logic [7:0] rd);
        logic [3:0] s;
        rd = '0;
        rx_q.push_back(b);
        if (quad) begin
            sclk_edge(b[7:4], s);
            rd[7:4] = s;
            sclk_edge(b[3:0], s);
            rd[3:0] = s;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                sclk_edge({3'b000, b[i]}, s);
                rd[i] = s[1];
            end
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [3:0] s;
        int r0, t0, u0, q0;

        rst_n      = 1'b0;
        spi_cs_n   = 1'b1;
        spi_sclk   = 1'b0;
        spi_dq_o   = '0;
        spi_dq_oen = '0;
        quad_en    = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_dq_i",   {28'h0, spi_dq_i}, 32'h0);
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_busy",   {31'h0, busy}, 32'h0);
        check("rst_pulses", {28'h0, rx_valid, tx_ready, tx_underrun, quad_conflict}, 32'h0);

        // Single mode, one byte each way; mid-transaction quad_en change ignored.
        r0 = n_rx; t0 = n_txr; u0 = n_und;
        tx_q.push_back(8'h3C);
        cs_start(1'b0);
        check("t1_busy", {31'h0, busy}, 32'h1);
        quad_en = 1'b1;
        xfer(8'hA5, 1'b0, rd);
        check("t1_master_rd", {24'h0, rd}, 32'h3C);
        cs_end();
        quad_en = 1'b0;
        check("t1_tx_ready_cnt", n_txr - t0, 1);
        check("t1_underrun_cnt", n_und - u0, 0);
        check("t1_rx_cnt", n_rx - r0, 1);
        check("t1_idle_busy", {31'h0, busy}, 32'h0);

        // Quad mode, three bytes each way.
        r0 = n_rx; t0 = n_txr; u0 = n_und; q0 = n_qc;
        tx_q.push_back(8'h9A);
        tx_q.push_back(8'hBC);
        tx_q.push_back(8'hDE);
        cs_start(1'b1);
        xfer(8'h12, 1'b1, rd);
        check("t2_rd0", {24'h0, rd}, 32'h9A);
        xfer(8'h34, 1'b1, rd);
        check("t2_rd1", {24'h0, rd}, 32'hBC);
        xfer(8'h56, 1'b1, rd);
        check("t2_rd2", {24'h0, rd}, 32'hDE);
        cs_end();
        check("t2_rx_cnt", n_rx - r0, 3);
        check("t2_tx_ready_cnt", n_txr - t0, 3);
        check("t2_underrun_cnt", n_und - u0, 0);
        check("t2_conflict_cnt", n_qc - q0, 0);

        // Underrun: no TX data for two single-mode bytes.
        r0 = n_rx; t0 = n_txr; u0 = n_und;
        cs_start(1'b0);
        xfer(8'h5A, 1'b0, rd);
        check("t3_rd0", {24'h0, rd}, 32'hFF);
        xfer(8'hC6, 1'b0, rd);
        check("t3_rd1", {24'h0, rd}, 32'hFF);
        cs_end();
        check("t3_underrun_cnt", n_und - u0, 2);
        check("t3_tx_ready_cnt", n_txr - t0, 0);
        check("t3_rx_cnt", n_rx - r0, 2);

        // Abort after five edges, then a clean byte.
        r0 = n_rx;
        cs_start(1'b0);
        for (int i = 0; i < 5; i++) sclk_edge({3'b000, 1'(i % 2)}, s);
        check("t4_busy_mid", {31'h0, busy}, 32'h1);
        cs_end();
        check("t4_rx_cnt_abort", n_rx - r0, 0);
        check("t4_busy", {31'h0, busy}, 32'h0);
        check("t4_dq_i", {28'h0, spi_dq_i}, 32'h0);
        cs_start(1'b0);
        xfer(8'h81, 1'b0, rd);
        cs_end();
        check("t4_rx_data", {24'h0, rx_data}, 32'h81);
        check("t4_rx_cnt", n_rx - r0, 1);

        // Quad conflict with the master still driving lane 0.
        r0 = n_rx; q0 = n_qc;
        cs_start(1'b1);
        spi_dq_oen = 4'b0001;
        xfer(8'hC3, 1'b1, rd);
        spi_dq_oen = 4'b0000;
        cs_end();
        check("t5_conflict_cnt", n_qc - q0, 2);
        check("t5_rx_cnt", n_rx - r0, 1);

        // Asynchronous reset mid-byte, then recovery.
        cs_start(1'b0);
        for (int i = 0; i < 3; i++) sclk_edge(4'b0001, s);
        check("t6_busy_pre", {31'h0, busy}, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_dq_i", {28'h0, spi_dq_i}, 32'h0);
        check("t6_rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_pulses", {28'h0, rx_valid, tx_ready, tx_underrun, quad_conflict}, 32'h0);
        @(negedge clk);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_dq_o = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        r0 = n_rx;
        cs_start(1'b0);
        xfer(8'h7E, 1'b0, rd);
        cs_end();
        check("t6_rx_data", {24'h0, rx_data}, 32'h7E);
        check("t6_rx_cnt", n_rx - r0, 1);

        check("rx_queue_drained", rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
